fifo_access_arbiter: RTL

FIFO_ACCESS_ARBITER -- requirements
Module: fifo_access_arbiter

---
 rtl/fifo_access_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter: round-robin multi-writer / single-reader access control for an external FIFO, with flush drain.
// Optional feature: define FIFO_ARB_WATERMARK_EN to enable the registered almost_full watermark output.
module fifo_access_arbiter #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int NUM_WR = 4,
  parameter int WMARK  = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_WR-1:0]          wr_req,
  input  logic [NUM_WR*WIDTH-1:0]    wr_data,
  output logic [NUM_WR-1:0]          wr_gnt,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       fifo_write,
  output logic                       fifo_read,
  output logic [WIDTH-1:0]           fifo_data_in,
  input  logic [WIDTH-1:0]           fifo_data_out,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       almost_full
);
  localparam int PW = NUM_WR > 1 ? $clog2(NUM_WR) : 1;
  localparam int OW = $clog2(DEPTH+1);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic pri, found, w_cand, r_cand, issue_w, issue_r;
  logic [PW-1:0] rr_ptr, win;
  logic [OW-1:0] occ_nx;
  logic [WIDTH-1:0] rd_hold;
  // Round-robin search for the first requester at or after rr_ptr
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      if (!found && wr_req[PW'((int'(rr_ptr) + i) % NUM_WR)]) begin
        found = 1'b1;
        win = PW'((int'(rr_ptr) + i) % NUM_WR);
      end
  end
  // Next state and strobes; a contested cycle is resolved by pri, and writes and reads never coincide
  always_comb begin
    state_nx = state;
    w_cand = state == RUN && |wr_req && !fifo_full;
    r_cand = state == RUN && rd_req && !fifo_empty;
    issue_w = w_cand && !(r_cand && pri);
    issue_r = r_cand && !issue_w;
    fifo_write = issue_w;
    fifo_read = issue_r || (state == DRAIN && !fifo_empty);
    wr_gnt = issue_w ? (NUM_WR'(1) << win) : '0;
    fifo_data_in = issue_w ? wr_data[int'(win)*WIDTH +: WIDTH] : '0;
    occ_nx = fifo_write && occupancy != OW'(DEPTH) ? occupancy + OW'(1) :
             fifo_read && occupancy != '0 ? occupancy - OW'(1) : occupancy;
    state_nx = state == RUN ? (flush ? DRAIN : RUN) : (fifo_empty ? RUN : DRAIN);
  end
  // Popped data is shown straight from the FIFO in its valid cycle and held afterwards
  assign rd_data = rd_valid ? fifo_data_out : rd_hold;
  // State, arbitration pointers, occupancy and read/flush handshakes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      pri <= 1'b0;
      rr_ptr <= '0;
      occupancy <= '0;
      rd_valid <= 1'b0;
      rd_hold <= '0;
      flush_done <= 1'b0;
    end else begin
      state <= state_nx;
      pri <= w_cand && r_cand ? !pri : pri;
      rr_ptr <= issue_w ? (win == PW'(NUM_WR-1) ? '0 : win + PW'(1)) : rr_ptr;
      occupancy <= occ_nx;
      rd_valid <= issue_r;
      rd_hold <= rd_valid ? fifo_data_out : rd_hold;
      flush_done <= state == DRAIN && fifo_empty;
    end
  end
`ifdef FIFO_ARB_WATERMARK_EN
  // Watermark flag registered alongside occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) almost_full <= 1'b0;
    else almost_full <= occ_nx >= OW'(WMARK);
  end
`else
  assign almost_full = 1'b0;
`endif
endmodule
